multicycle_cu: RTL and testbench
================================

Name: multicycle_cu

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath; replaces single-cycle combinational control when instruction and data memories have variable latency.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the datapath's existing control buses (reg2loc, seu, aluSrc, aluOp, memWr, memToReg, regWr, pcSrc) plus PC/IR write enables and memory read strobes.
- Counts retired instructions and traps on undefined opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max consecutive cycles mem_ready may stay low in FETCH or MEM before FAULT; 0 disables the timeout.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  11  instr[31:21] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; request completes in the cycle it is high.
- bus_pcWr  out  1  PC register write enable.
- bus_irWr  out  1  instruction register write enable.
- bus_reg2loc  out  1  register read-port-2 select.
- bus_seu  out  2  immediate format: 00 ALU-imm/shift, 01 D-type, 10 B, 11 CB.
- bus_aluSrc  out  1  ALU B operand: 0 register, 1 immediate.
- bus_aluOp  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 pass-B, 101 LSL, 110 LSR.
- bus_memRd  out  1  memory read request; instruction fetch in FETCH, data load in MEM.
- bus_memWr  out  1  data memory write request.
- bus_memToReg  out  1  write-back source: 1 memory, 0 ALU.
- bus_regWr  out  1  register file write enable.
- bus_pcSrc  out  1  PC mux: 0 PC+4, 1 branch target.
- state  out  3  current state, for debug.
- fault  out  1  sticky trap flag.
- instr_count  out  COUNT_W  retired-instruction count.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Reset:
  - state=FETCH, fault=0, instr_count=0, wait_cnt=0, op_class=NOP.
  - All enables and strobes 0; bus_aluOp=000; bus_seu=00.
  - rst overrides everything, including mid-memory-wait and FAULT.
- Outputs decode combinationally from state and the registered op_class. Exception: bus_pcWr in EXEC for CBZ/CBNZ also depends on zero.
- Controls that are don't-care in a state drive 0.
- FETCH:
  - bus_memRd=1.
  - mem_ready=1: bus_irWr=1, bus_pcWr=1, bus_pcSrc=0, go to DECODE.
  - Otherwise stay and increment wait_cnt.
- DECODE (1 cycle):
  - Classify opcode into op_class and register it; later opcode changes are ignored.
  - Classes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, B 000101xxxxx, CBZ 10110100xxx, CBNZ 10110101xxx, ADDI 1001000100x, SUBI 1101000100x, ANDI 1001001000x, ORRI 1011001000x, LSL 11010011011, LSR 11010011010.
  - Unmatched opcode goes to FAULT; otherwise to EXEC.
  - bus_reg2loc=1 for STUR/CBZ/CBNZ, else 0; held through EXEC and MEM.
- EXEC (1 cycle):
  - R-type: aluSrc=0, aluOp per op, then WB.
  - I-type and shifts: seu=00, aluSrc=1, aluOp per op, then WB.
  - LDUR/STUR: seu=01, aluSrc=1, aluOp=000, then MEM.
  - B: seu=10, pcSrc=1, pcWr=1, retire, then FETCH.
  - CBZ/CBNZ: seu=11, aluSrc=0, aluOp=100, pcSrc=1. pcWr=zero for CBZ, pcWr=!zero for CBNZ. Retire, then FETCH.
- MEM:
  - seu=01, aluSrc=1, aluOp=000 held so the address stays stable.
  - LDUR: memRd=1 until mem_ready, then WB.
  - STUR: memWr=1 until mem_ready, then retire and go to FETCH.
- WB (1 cycle):
  - regWr=1, memToReg=1 for LDUR else 0, aluOp/aluSrc/seu held.
  - Retire, then FETCH.
- Timeout:
  - wait_cnt clears on every state change.
  - If MEM_TIMEOUT≠0, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1, go to FAULT next cycle.
  - mem_ready=1 in that same cycle wins; no fault.
- FAULT:
  - fault=1; all strobes, pcWr, irWr, regWr, memWr 0.
  - Stays until rst.
- Retire: instr_count increments by 1 on the retiring cycle and wraps modulo 2^COUNT_W.
- Latency with mem_ready tied high: R/I-type 4 cycles; LDUR 5; STUR 4; B/CBZ/CBNZ 3.

Test Plan:
- ADD, mem_ready=1 -> states 0,1,2,4,0; regWr=1 only in cycle 4; aluOp=000; instr_count=1.
- LDUR, mem_ready low 3 cycles in MEM -> memRd=1 for 4 MEM cycles; WB memToReg=1, regWr=1; 8 cycles total.
- CBZ with zero=1, then CBNZ with zero=1 -> CBZ: pcWr=1, pcSrc=1 in EXEC. CBNZ: pcWr=0. Both return to FETCH, instr_count=2.
- Opcode 11111111111 -> DECODE goes to FAULT; fault=1; all strobes 0 for 20 cycles; rst returns to FETCH with count 0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 cycles. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no fault.
- rst asserted during the STUR MEM wait -> memWr drops next cycle; state=FETCH; no retire.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle control sequencer for the LEGv8 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, tolerates
// variable-latency memories via mem_ready, counts retired instructions
// and traps on undefined opcodes or memory timeouts.
module multicycle_cu #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               bus_pcWr,
    output logic               bus_irWr,
    output logic               bus_reg2loc,
    output logic [1:0]         bus_seu,
    output logic               bus_aluSrc,
    output logic [2:0]         bus_aluOp,
    output logic               bus_memRd,
    output logic               bus_memWr,
    output logic               bus_memToReg,
    output logic               bus_regWr,
    output logic               bus_pcSrc,
    output logic [2:0]         state,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_B,
        C_CBZ, C_CBNZ, C_ADDI, C_SUBI, C_ANDI, C_ORRI, C_LSL, C_LSR
    } op_class_e;

    state_e              state_q, state_d;
    op_class_e           class_q, class_d;
    op_class_e           dec_class;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                fault_q, fault_d;
    logic                retire;
    logic                mem_timeout;
    logic                waiting;

    logic [2:0]          cls_alu_op;
    logic                cls_alu_src;
    logic [1:0]          cls_seu;
    logic                cls_reg2loc;
    logic                dec_reg2loc;

    // Opcode classification, only latched while in DECODE
    always_comb begin
        dec_class = C_NOP;
        casez (opcode)
            11'b10001011000: dec_class = C_ADD;
            11'b11001011000: dec_class = C_SUB;
            11'b10001010000: dec_class = C_AND;
            11'b10101010000: dec_class = C_ORR;
            11'b11111000010: dec_class = C_LDUR;
            11'b11111000000: dec_class = C_STUR;
            11'b000101?????: dec_class = C_B;
            11'b10110100???: dec_class = C_CBZ;
            11'b10110101???: dec_class = C_CBNZ;
            11'b1001000100?: dec_class = C_ADDI;
            11'b1101000100?: dec_class = C_SUBI;
            11'b1001001000?: dec_class = C_ANDI;
            11'b1011001000?: dec_class = C_ORRI;
            11'b11010011011: dec_class = C_LSL;
            11'b11010011010: dec_class = C_LSR;
            default:         dec_class = C_NOP;
        endcase
    end

    // Datapath settings implied by the registered class (shared by EXEC, MEM, WB)
    always_comb begin
        cls_alu_op  = 3'b000;
        cls_alu_src = 1'b0;
        cls_seu     = 2'b00;
        case (class_q)
            C_ADD:          cls_alu_op = 3'b000;
            C_SUB:          cls_alu_op = 3'b001;
            C_AND:          cls_alu_op = 3'b010;
            C_ORR:          cls_alu_op = 3'b011;
            C_ADDI:         begin cls_alu_op = 3'b000; cls_alu_src = 1'b1; end
            C_SUBI:         begin cls_alu_op = 3'b001; cls_alu_src = 1'b1; end
            C_ANDI:         begin cls_alu_op = 3'b010; cls_alu_src = 1'b1; end
            C_ORRI:         begin cls_alu_op = 3'b011; cls_alu_src = 1'b1; end
            C_LSL:          begin cls_alu_op = 3'b101; cls_alu_src = 1'b1; end
            C_LSR:          begin cls_alu_op = 3'b110; cls_alu_src = 1'b1; end
            C_LDUR, C_STUR: begin cls_seu = 2'b01; cls_alu_src = 1'b1; end
            C_B:            cls_seu = 2'b10;
            C_CBZ, C_CBNZ:  begin cls_seu = 2'b11; cls_alu_op = 3'b100; end
            default:        cls_alu_op = 3'b000;
        endcase
    end

    // Read port 2 must see Rt for stores and compare-branches; DECODE uses the live opcode
    assign cls_reg2loc = (class_q == C_STUR) || (class_q == C_CBZ) || (class_q == C_CBNZ);
    assign dec_reg2loc = (dec_class == C_STUR) || (dec_class == C_CBZ) || (dec_class == C_CBNZ);

    assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign mem_timeout = (MEM_TIMEOUT != 0) && waiting &&
                         (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state, class latch, retire and timeout bookkeeping
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (mem_timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                class_d = dec_class;
                state_d = (dec_class == C_NOP) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                if ((class_q == C_B) || (class_q == C_CBZ) || (class_q == C_CBNZ)) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if ((class_q == C_LDUR) || (class_q == C_STUR)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (class_q == C_LDUR) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (mem_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        if (state_d != state_q) wait_cnt_d = '0;
        else if (waiting)       wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        else                    wait_cnt_d = wait_cnt_q;

        count_d = count_q + COUNT_W'(retire);
        fault_d = fault_q || (state_d == S_FAULT);
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            class_q    <= C_NOP;
            wait_cnt_q <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            wait_cnt_q <= wait_cnt_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // Control-bus decode from state and registered class
    always_comb begin
        bus_pcWr     = 1'b0;
        bus_irWr     = 1'b0;
        bus_reg2loc  = 1'b0;
        bus_seu      = 2'b00;
        bus_aluSrc   = 1'b0;
        bus_aluOp    = 3'b000;
        bus_memRd    = 1'b0;
        bus_memWr    = 1'b0;
        bus_memToReg = 1'b0;
        bus_regWr    = 1'b0;
        bus_pcSrc    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus_memRd = 1'b1;
                if (mem_ready) begin
                    bus_irWr = 1'b1;
                    bus_pcWr = 1'b1;
                end
            end
            S_DECODE: bus_reg2loc = dec_reg2loc;
            S_EXEC: begin
                bus_reg2loc = cls_reg2loc;
                bus_seu     = cls_seu;
                bus_aluSrc  = cls_alu_src;
                bus_aluOp   = cls_alu_op;
                case (class_q)
                    C_B:     begin bus_pcSrc = 1'b1; bus_pcWr = 1'b1;  end
                    C_CBZ:   begin bus_pcSrc = 1'b1; bus_pcWr = zero;  end
                    C_CBNZ:  begin bus_pcSrc = 1'b1; bus_pcWr = !zero; end
                    default: bus_pcSrc = 1'b0;
                endcase
            end
            S_MEM: begin
                bus_reg2loc = cls_reg2loc;
                bus_seu     = 2'b01;
                bus_aluSrc  = 1'b1;
                bus_aluOp   = 3'b000;
                bus_memRd   = (class_q == C_LDUR);
                bus_memWr   = (class_q == C_STUR);
            end
            S_WB: begin
                bus_regWr    = 1'b1;
                bus_memToReg = (class_q == C_LDUR);
                bus_seu      = cls_seu;
                bus_aluSrc   = cls_alu_src;
                bus_aluOp    = cls_alu_op;
            end
            default: bus_pcWr = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: per-cycle expected state/control
// records are queued as stimulus is applied and compared on the falling edge.
module tb_multicycle_cu;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned COUNT_W     = 4;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_B    = 11'b00010111011;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_CBNZ = 11'b10110101010;
    localparam logic [10:0] OP_SUBI = 11'b11010001001;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    typedef struct packed {
        logic [2:0]  st;
        logic        flt;
        logic [13:0] c;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [10:0]        opcode;
    logic               zero;
    logic               mem_ready;
    logic               bus_pcWr, bus_irWr, bus_reg2loc, bus_aluSrc;
    logic [1:0]         bus_seu;
    logic [2:0]         bus_aluOp;
    logic               bus_memRd, bus_memWr, bus_memToReg, bus_regWr, bus_pcSrc;
    logic [2:0]         state;
    logic               fault;
    logic [COUNT_W-1:0] instr_count;
    logic [13:0]        ctrl_obs;

    exp_t               sb_q[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [COUNT_W-1:0] exp_cnt;
    logic [13:0]        c_fetch, c_fwait;

    multicycle_cu #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .bus_pcWr     (bus_pcWr),
        .bus_irWr     (bus_irWr),
        .bus_reg2loc  (bus_reg2loc),
        .bus_seu      (bus_seu),
        .bus_aluSrc   (bus_aluSrc),
        .bus_aluOp    (bus_aluOp),
        .bus_memRd    (bus_memRd),
        .bus_memWr    (bus_memWr),
        .bus_memToReg (bus_memToReg),
        .bus_regWr    (bus_regWr),
        .bus_pcSrc    (bus_pcSrc),
        .state        (state),
        .fault        (fault),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    assign ctrl_obs = {bus_pcWr, bus_irWr, bus_reg2loc, bus_seu, bus_aluSrc, bus_aluOp,
                       bus_memRd, bus_memWr, bus_memToReg, bus_regWr, bus_pcSrc};

    function automatic logic [13:0] ctl(input logic pcwr, input logic irwr, input logic r2l,
                                        input logic [1:0] seu, input logic asrc,
                                        input logic [2:0] aop, input logic mrd,
                                        input logic mwr, input logic m2r,
                                        input logic rwr, input logic psrc);
        return {pcwr, irwr, r2l, seu, asrc, aop, mrd, mwr, m2r, rwr, psrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected record, compare on the falling edge
    task automatic cyc(input string tag, input logic [10:0] op, input logic z,
                       input logic rdy, input logic [2:0] st, input logic [13:0] c);
        exp_t e;
        exp_t got;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        e.st  = st;
        e.flt = (st == ST_FAULT);
        e.c   = c;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk({tag, ".state"}, 32'(state),    32'(got.st));
        chk({tag, ".fault"}, 32'(fault),    32'(got.flt));
        chk({tag, ".ctrl"},  32'(ctrl_obs), 32'(got.c));
        @(posedge clk);
        #1;
    endtask

    task automatic retired(input string tag);
        exp_cnt = exp_cnt + COUNT_W'(1);
        chk({tag, ".count"}, 32'(instr_count), 32'(exp_cnt));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = '0;
        chk({tag, ".state"}, 32'(state),       32'(ST_FETCH));
        chk({tag, ".fault"}, 32'(fault),       32'(0));
        chk({tag, ".count"}, 32'(instr_count), 32'(exp_cnt));
    endtask

    task automatic run_b(input string tag);
        cyc(tag, OP_B, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc(tag, OP_B, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc(tag, OP_B, 1'b0, 1'b0, ST_EXEC,   ctl(1,0,0,2'b10,0,3'b000,0,0,0,0,1));
        retired(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        c_fetch   = ctl(1,1,0,2'b00,0,3'b000,1,0,0,0,0);
        c_fwait   = ctl(0,0,0,2'b00,0,3'b000,1,0,0,0,0);
        exp_cnt   = '0;
        rst       = 1'b1;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset state (memRd masked: FETCH requests fetch while reset is held)
        @(posedge clk);
        #1;
        chk("rst.state", 32'(state),               32'(ST_FETCH));
        chk("rst.fault", 32'(fault),               32'(0));
        chk("rst.count", 32'(instr_count),         32'(0));
        chk("rst.ctrl",  32'(ctrl_obs & 14'h3FEF), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD with memory always ready
        cyc("add", OP_ADD, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("add", OP_ADD, 1'b0, 1'b1, ST_DECODE, 14'h0);
        cyc("add", OP_ADD, 1'b0, 1'b1, ST_EXEC,   14'h0);
        cyc("add", OP_ADD, 1'b0, 1'b1, ST_WB,     ctl(0,0,0,2'b00,0,3'b000,0,0,0,1,0));
        retired("add");

        // LDUR with three wait cycles in MEM
        cyc("ldur", OP_LDUR, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("ldur", OP_LDUR, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("ldur", OP_LDUR, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,0,2'b01,1,3'b000,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            cyc("ldur.mem", OP_LDUR, 1'b0, (i == 3), ST_MEM, ctl(0,0,0,2'b01,1,3'b000,1,0,0,0,0));
        cyc("ldur", OP_LDUR, 1'b0, 1'b0, ST_WB,     ctl(0,0,0,2'b01,1,3'b000,0,0,1,1,0));
        retired("ldur");

        // CBZ taken, then CBNZ not taken, both with zero=1
        cyc("cbz", OP_CBZ, 1'b1, 1'b1, ST_FETCH,  c_fetch);
        cyc("cbz", OP_CBZ, 1'b1, 1'b0, ST_DECODE, ctl(0,0,1,2'b00,0,3'b000,0,0,0,0,0));
        cyc("cbz", OP_CBZ, 1'b1, 1'b0, ST_EXEC,   ctl(1,0,1,2'b11,0,3'b100,0,0,0,0,1));
        retired("cbz");
        cyc("cbnz", OP_CBNZ, 1'b1, 1'b1, ST_FETCH,  c_fetch);
        cyc("cbnz", OP_CBNZ, 1'b1, 1'b0, ST_DECODE, ctl(0,0,1,2'b00,0,3'b000,0,0,0,0,0));
        cyc("cbnz", OP_CBNZ, 1'b1, 1'b0, ST_EXEC,   ctl(0,0,1,2'b11,0,3'b100,0,0,0,0,1));
        retired("cbnz");

        run_b("b");

        // Immediate and shift forms
        cyc("subi", OP_SUBI, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("subi", OP_SUBI, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("subi", OP_SUBI, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,0,2'b00,1,3'b001,0,0,0,0,0));
        cyc("subi", OP_SUBI, 1'b0, 1'b0, ST_WB,     ctl(0,0,0,2'b00,1,3'b001,0,0,0,1,0));
        retired("subi");
        cyc("lsr", OP_LSR, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("lsr", OP_LSR, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("lsr", OP_LSR, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,0,2'b00,1,3'b110,0,0,0,0,0));
        cyc("lsr", OP_LSR, 1'b0, 1'b0, ST_WB,     ctl(0,0,0,2'b00,1,3'b110,0,0,0,1,0));
        retired("lsr");

        // ORR: opcode changes after DECODE must not matter
        cyc("orr", OP_ORR, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("orr", OP_ORR, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("orr", OP_BAD, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,0,2'b00,0,3'b011,0,0,0,0,0));
        cyc("orr", OP_BAD, 1'b0, 1'b0, ST_WB,     ctl(0,0,0,2'b00,0,3'b011,0,0,0,1,0));
        retired("orr");

        // STUR with memory ready
        cyc("stur", OP_STUR, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("stur", OP_STUR, 1'b0, 1'b0, ST_DECODE, ctl(0,0,1,2'b00,0,3'b000,0,0,0,0,0));
        cyc("stur", OP_STUR, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,1,2'b01,1,3'b000,0,0,0,0,0));
        cyc("stur", OP_STUR, 1'b0, 1'b1, ST_MEM,    ctl(0,0,1,2'b01,1,3'b000,0,1,0,0,0));
        retired("stur");

        // Counter wraps modulo 2^COUNT_W
        for (int i = 0; i < 8; i++) run_b("bwrap");

        // Fetch ready on the last allowed wait cycle: no fault
        for (int i = 0; i < 3; i++) cyc("fwait", OP_ADD, 1'b0, 1'b0, ST_FETCH, c_fwait);
        cyc("fwait", OP_ADD, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("fwait", OP_ADD, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("fwait", OP_ADD, 1'b0, 1'b0, ST_EXEC,   14'h0);
        cyc("fwait", OP_ADD, 1'b0, 1'b0, ST_WB,     ctl(0,0,0,2'b00,0,3'b000,0,0,0,1,0));
        retired("fwait");

        // LDUR data-memory timeout
        cyc("mto", OP_LDUR, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("mto", OP_LDUR, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("mto", OP_LDUR, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,0,2'b01,1,3'b000,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            cyc("mto.mem", OP_LDUR, 1'b0, 1'b0, ST_MEM, ctl(0,0,0,2'b01,1,3'b000,1,0,0,0,0));
        for (int i = 0; i < 20; i++)
            cyc("mto.fault", 11'($urandom), 1'($urandom), 1'($urandom), ST_FAULT, 14'h0);
        do_reset("mto.rst");

        // Fetch timeout
        for (int i = 0; i < 4; i++) cyc("fto", OP_ADD, 1'b0, 1'b0, ST_FETCH, c_fwait);
        for (int i = 0; i < 3; i++) cyc("fto.fault", OP_ADD, 1'b0, 1'b1, ST_FAULT, 14'h0);
        do_reset("fto.rst");

        // Undefined opcode
        cyc("bad", OP_BAD, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("bad", OP_BAD, 1'b0, 1'b1, ST_DECODE, 14'h0);
        for (int i = 0; i < 20; i++)
            cyc("bad.fault", 11'($urandom), 1'($urandom), 1'($urandom), ST_FAULT, 14'h0);
        do_reset("bad.rst");

        // Reset in the middle of a STUR memory wait
        cyc("add2", OP_ADD, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("add2", OP_ADD, 1'b0, 1'b0, ST_DECODE, 14'h0);
        cyc("add2", OP_ADD, 1'b0, 1'b0, ST_EXEC,   14'h0);
        cyc("add2", OP_ADD, 1'b0, 1'b0, ST_WB,     ctl(0,0,0,2'b00,0,3'b000,0,0,0,1,0));
        retired("add2");
        cyc("srst", OP_STUR, 1'b0, 1'b1, ST_FETCH,  c_fetch);
        cyc("srst", OP_STUR, 1'b0, 1'b0, ST_DECODE, ctl(0,0,1,2'b00,0,3'b000,0,0,0,0,0));
        cyc("srst", OP_STUR, 1'b0, 1'b0, ST_EXEC,   ctl(0,0,1,2'b01,1,3'b000,0,0,0,0,0));
        cyc("srst", OP_STUR, 1'b0, 1'b0, ST_MEM,    ctl(0,0,1,2'b01,1,3'b000,0,1,0,0,0));
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("srst.hold.state", 32'(state),     32'(ST_MEM));
        chk("srst.hold.memWr", 32'(bus_memWr), 32'(1));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = '0;
        chk("srst.count", 32'(instr_count), 32'(exp_cnt));
        cyc("srst.after", OP_STUR, 1'b0, 1'b0, ST_FETCH, c_fwait);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
